// File: rtl/exu_dispatch_q.sv
// rtl/exu_dispatch_q.sv - in-order issue queue between decode and the execute channels
// Head entry's group field selects a one-hot channel request; illegal groups self-drop with a pulse.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif
`ifndef DECINFO_GRP_WIDTH
`define DECINFO_GRP_WIDTH 3
`endif

module exu_dispatch_q #(
  parameter int DATA_W  = 32,
  parameter int INFO_W  = `DECINFO_WIDTH,
  parameter int GRP_W   = `DECINFO_GRP_WIDTH,
  parameter int NUM_GRP = 6,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       dec_valid_i,
  output logic                       dec_ready_o,
  input  logic [INFO_W-1:0]          dec_info_bus_i,
  input  logic [DATA_W-1:0]          dec_imm_i,
  input  logic [DATA_W-1:0]          dec_pc_i,
  input  logic [DATA_W-1:0]          rs1_rdata_i,
  input  logic [DATA_W-1:0]          rs2_rdata_i,
  output logic [NUM_GRP-1:0]         req_o,
  input  logic [NUM_GRP-1:0]         ack_i,
  output logic [INFO_W-1:0]          disp_info_o,
  output logic [DATA_W-1:0]          disp_imm_o,
  output logic [DATA_W-1:0]          disp_pc_o,
  output logic [DATA_W-1:0]          disp_rs1_o,
  output logic [DATA_W-1:0]          disp_rs2_o,
  output logic                       illegal_o,
  output logic [DATA_W-1:0]          illegal_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INFO_W-1:0] info_mem [DEPTH];
  logic [DATA_W-1:0] imm_mem  [DEPTH];
  logic [DATA_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] rs1_mem  [DEPTH];
  logic [DATA_W-1:0] rs2_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              head_valid;
  logic [GRP_W-1:0]  head_grp;
  logic [31:0]       head_grp_ext;
  logic              head_legal;
  logic [NUM_GRP-1:0] req;
  logic              issue;
  logic              push;
  logic              pop;

  // Full is judged on the registered count only, so a pop never frees a slot in the same cycle.
  assign dec_ready_o = (count_q != CNT_W'(DEPTH));
  assign push        = dec_valid_i & dec_ready_o & ~flush_i;

  assign head_valid   = (count_q != '0);
  assign head_grp     = info_mem[rd_ptr_q][GRP_W-1:0];
  assign head_grp_ext = 32'(head_grp);
  assign head_legal   = (head_grp_ext < NUM_GRP);

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_GRP; i++) begin
      req[i] = head_valid & head_legal & (head_grp_ext == 32'(i));
    end
  end

  assign issue     = |req;
  assign illegal_o = head_valid & ~head_legal;
  assign pop       = (|(req & ack_i)) | illegal_o;

  assign req_o        = req;
  assign disp_info_o  = issue ? info_mem[rd_ptr_q] : '0;
  assign disp_imm_o   = issue ? imm_mem[rd_ptr_q]  : '0;
  assign disp_pc_o    = issue ? pc_mem[rd_ptr_q]   : '0;
  assign disp_rs1_o   = issue ? rs1_mem[rd_ptr_q]  : '0;
  assign disp_rs2_o   = issue ? rs2_mem[rd_ptr_q]  : '0;
  assign illegal_pc_o = illegal_o ? pc_mem[rd_ptr_q] : '0;
  assign count_o      = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      info_mem[wr_ptr_q] <= dec_info_bus_i;
      imm_mem[wr_ptr_q]  <= dec_imm_i;
      pc_mem[wr_ptr_q]   <= dec_pc_i;
      rs1_mem[wr_ptr_q]  <= rs1_rdata_i;
      rs2_mem[wr_ptr_q]  <= rs2_rdata_i;
    end
  end

endmodule

// File: tb/tb_exu_dispatch_q.sv
// tb/tb_exu_dispatch_q.sv - scenario tasks plus randomized traffic against a queue model
module tb_exu_dispatch_q;

  typedef struct {
    logic [31:0] info;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, dec_valid_i, dec_ready_o, illegal_o;
  logic [31:0] dec_info_bus_i, dec_imm_i, dec_pc_i, rs1_rdata_i, rs2_rdata_i;
  logic [5:0]  req_o, ack_i;
  logic [31:0] disp_info_o, disp_imm_o, disp_pc_o, disp_rs1_o, disp_rs2_o, illegal_pc_o;
  logic [2:0]  count_o;

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  logic [31:0] issued[$];

  always #5 clk = ~clk;

  exu_dispatch_q #(.DATA_W(32), .INFO_W(32), .GRP_W(3), .NUM_GRP(6), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_info_bus_i(dec_info_bus_i), .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i),
    .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
    .req_o(req_o), .ack_i(ack_i),
    .disp_info_o(disp_info_o), .disp_imm_o(disp_imm_o), .disp_pc_o(disp_pc_o),
    .disp_rs1_o(disp_rs1_o), .disp_rs2_o(disp_rs2_o),
    .illegal_o(illegal_o), .illegal_pc_o(illegal_pc_o), .count_o(count_o)
  );

  task automatic drive(input logic v, input logic [2:0] g, input logic [31:0] pc,
                       input logic [5:0] ack, input logic fl);
    @(negedge clk);
    dec_valid_i    = v;
    dec_info_bus_i = $urandom;
    dec_info_bus_i[2:0] = g;
    dec_pc_i       = pc;
    dec_imm_i      = $urandom;
    rs1_rdata_i    = $urandom;
    rs2_rdata_i    = $urandom;
    ack_i          = ack;
    flush_i        = fl;
    #1;
  endtask

  // Reference: a FIFO of instructions; the oldest issues to its group's channel when acked.
  function automatic void advance();
    bit   pop = 0;
    bit   push;
    int   g;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      return;
    end
    if (mq.size() != 0) begin
      g = int'(mq[0].info[2:0]);
      if (g >= 6) pop = 1;
      else if (ack_i[g]) begin
        pop = 1;
        issued.push_back(mq[0].pc);
      end
    end
    push = dec_valid_i && (mq.size() != 4) && !flush_i;
    if (flush_i) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.info = dec_info_bus_i; e.imm = dec_imm_i; e.pc = dec_pc_i;
        e.rs1 = rs1_rdata_i; e.rs2 = rs2_rdata_i;
        mq.push_back(e);
      end
    end
  endfunction

  function automatic void model_out(output logic [5:0] r, output ent_t p,
                                    output logic il, output logic [31:0] ipc);
    int g;
    r = '0; il = 1'b0; ipc = '0;
    p.info = '0; p.imm = '0; p.pc = '0; p.rs1 = '0; p.rs2 = '0;
    if (mq.size() != 0) begin
      g = int'(mq[0].info[2:0]);
      if (g >= 6) begin
        il = 1'b1;
        ipc = mq[0].pc;
      end else begin
        r = 6'd1 << g;
        p = mq[0];
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin drive(0, 0, 0, '0, 0); advance(); end
    drive(0, 0, 0, '0, 0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", dec_ready_o); end
    checks++; if ({req_o, illegal_o} !== 7'd0) begin errors++; $display("FAIL reset_req got %b/%b exp 0", req_o, illegal_o); end
    checks++; if ({disp_info_o, disp_imm_o, disp_pc_o, disp_rs1_o, disp_rs2_o, illegal_pc_o} !== '0) begin
      errors++; $display("FAIL reset_payload got pc %h exp 0", disp_pc_o); end
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_alu_issue();
    drive(1, 0, 32'h100, 6'h3f, 0); advance();
    drive(0, 0, 0, 6'h3f, 0);
    checks++; if (req_o !== 6'b000001) begin errors++; $display("FAIL alu_req got %b exp 000001", req_o); end
    checks++; if (disp_pc_o !== 32'h100) begin errors++; $display("FAIL alu_pc got %h exp 100", disp_pc_o); end
    advance();
    drive(0, 0, 0, 6'h3f, 0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL alu_count got %0d exp 0", count_o); end
    checks++; if ({req_o, disp_info_o, disp_imm_o, disp_pc_o, disp_rs1_o, disp_rs2_o} !== '0) begin
      errors++; $display("FAIL alu_idle got req %b pc %h exp 0", req_o, disp_pc_o); end
    advance();
  endtask

  task automatic test_full_drain();
    for (int i = 0; i < 4; i++) begin drive(1, 2, 32'(4 * i), '0, 0); advance(); end
    drive(1, 2, 32'h10, '0, 0);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count_o); end
    checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", dec_ready_o); end
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 6'b000100, 0);
      checks++; if (count_o !== 3'(4 - i)) begin errors++; $display("FAIL drain_count%0d got %0d exp %0d", i, count_o, 4 - i); end
      checks++; if (req_o !== 6'b000100 || disp_pc_o !== 32'(4 * i)) begin
        errors++; $display("FAIL drain_pc%0d got req %b pc %h exp 000100 %h", i, req_o, disp_pc_o, 4 * i); end
      advance();
    end
    drive(0, 0, 0, '0, 0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL drain_empty got %0d exp 0", count_o); end
    advance();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin drive(1, 5, 32'h500 + 32'(4 * i), '0, 0); advance(); end
    drive(1, 5, 32'h5f0, 6'b100000, 0);
    checks++; if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL fpp_ready got %b exp 0", dec_ready_o); end
    checks++; if (req_o !== 6'b100000 || disp_pc_o !== 32'h500) begin
      errors++; $display("FAIL fpp_head got %b %h exp 100000 500", req_o, disp_pc_o); end
    advance();
    drive(0, 0, 0, '0, 0);
    checks++; if (count_o !== 3'd3 || dec_ready_o !== 1'b1) begin
      errors++; $display("FAIL fpp_after got count %0d ready %b exp 3 1", count_o, dec_ready_o); end
    advance();
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 6'h3f, 0);
      checks++; if (disp_pc_o !== 32'h500 + 32'(4 * i)) begin
        errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, disp_pc_o, 32'h500 + 4 * i); end
      advance();
    end
    drive(0, 0, 0, 6'h3f, 0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL fpp_empty got %0d exp 0", count_o); end
    advance();
  endtask

  task automatic test_illegal();
    drive(1, 7, 32'h200, 6'h3f, 0); advance();
    drive(1, 1, 32'h204, 6'h3f, 0);
    checks++; if (illegal_o !== 1'b1 || illegal_pc_o !== 32'h200 || req_o !== 6'd0) begin
      errors++; $display("FAIL illegal_head got il %b pc %h req %b exp 1 200 0", illegal_o, illegal_pc_o, req_o); end
    advance();
    drive(0, 0, 0, 6'h3f, 0);
    checks++; if (illegal_o !== 1'b0 || illegal_pc_o !== 32'd0) begin
      errors++; $display("FAIL illegal_pulse got il %b pc %h exp 0 0", illegal_o, illegal_pc_o); end
    checks++; if (req_o !== 6'b000010 || disp_pc_o !== 32'h204) begin
      errors++; $display("FAIL illegal_next got %b %h exp 000010 204", req_o, disp_pc_o); end
    advance();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive(1, 3, 32'h300 + 32'(4 * i), '0, 0); advance(); end
    drive(1, 0, 32'h3f0, '0, 1);
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", count_o); end
    advance();
    drive(0, 0, 0, '0, 0);
    checks++; if (count_o !== 3'd0 || req_o !== 6'd0 || dec_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_post got count %0d req %b ready %b exp 0 0 1", count_o, req_o, dec_ready_o); end
    advance();
    drive(1, 4, 32'h400, '0, 0); advance();
    drive(0, 0, 0, 6'h3f, 0);
    checks++; if (req_o !== 6'b010000 || disp_pc_o !== 32'h400 || count_o !== 3'd1) begin
      errors++; $display("FAIL flush_repush got %b %h %0d exp 010000 400 1", req_o, disp_pc_o, count_o); end
    advance();
  endtask

  task automatic test_back_to_back();
    issued.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'($urandom_range(0, 5)), 32'h1000 + 32'(4 * i), 6'h3f, 0);
      if (i > 0) begin
        checks++; if (!$onehot(req_o) || disp_pc_o !== 32'h1000 + 32'(4 * (i - 1)) || count_o !== 3'd1) begin
          errors++; $display("FAIL b2b_%0d got req %b pc %h count %0d", i, req_o, disp_pc_o, count_o); end
      end
      advance();
    end
    drive(0, 0, 0, 6'h3f, 0); advance();
    drive(0, 0, 0, 6'h3f, 0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", count_o); end
    advance();
    checks++; if (issued.size() != 10) begin errors++; $display("FAIL b2b_n got %0d exp 10", issued.size()); end
    for (int i = 0; i < issued.size() && i < 10; i++) begin
      checks++; if (issued[i] !== 32'h1000 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b_order%0d got %h exp %h", i, issued[i], 32'h1000 + 4 * i); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  er;
    ent_t        ep;
    logic        eil;
    logic [31:0] eipc;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
            6'($urandom), $urandom_range(0, 19) == 0);
      model_out(er, ep, eil, eipc);
      checks++; if (req_o !== er) begin errors++; $display("FAIL rnd_req%0d got %b exp %b", n, req_o, er); end
      checks++; if ({disp_info_o, disp_imm_o, disp_pc_o, disp_rs1_o, disp_rs2_o} !== {ep.info, ep.imm, ep.pc, ep.rs1, ep.rs2}) begin
        errors++; $display("FAIL rnd_payload%0d got pc %h exp %h", n, disp_pc_o, ep.pc); end
      checks++; if (illegal_o !== eil || illegal_pc_o !== eipc) begin
        errors++; $display("FAIL rnd_illegal%0d got %b %h exp %b %h", n, illegal_o, illegal_pc_o, eil, eipc); end
      checks++; if (count_o !== 3'(mq.size()) || dec_ready_o !== (mq.size() != 4)) begin
        errors++; $display("FAIL rnd_count%0d got %0d %b exp %0d", n, count_o, dec_ready_o, mq.size()); end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; dec_valid_i = 1'b0; ack_i = '0;
    dec_info_bus_i = '0; dec_imm_i = '0; dec_pc_i = '0; rs1_rdata_i = '0; rs2_rdata_i = '0;
    test_reset();
    test_alu_issue();
    test_full_drain();
    test_full_push_pop();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_dispatch_q.md
Name: exu_dispatch_q

Overview:
Parametrised successor to the combinational execute dispatcher: a DEPTH-entry in-order issue queue between decode and the execute units. It decouples decode from multi-cycle units (MULDIV, MEM) through per-unit valid/ready handshakes. It decodes the head entry's group field into a one-hot per-unit valid, gates the payload to zero when nothing issues, traps illegal group codes, and supports pipeline flush.

Parameters:
DATA_W, 32, width of pc/imm/rs1/rs2 payload
INFO_W, `DECINFO_WIDTH, width of decode info bus
GRP_W, `DECINFO_GRP_WIDTH, width of group field, located at dec_info_bus_i[GRP_W-1:0]
NUM_GRP, 6, number of execute channels; group code g in 0..NUM_GRP-1 maps to channel g
DEPTH, 4, queue entries; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  discard all queued entries (branch/trap redirect)
dec_valid_i  in  1  decode presents an instruction
dec_ready_o  out  1  queue can accept (count != DEPTH)
dec_info_bus_i  in  INFO_W  decoded info incl. group field
dec_imm_i  in  DATA_W  immediate
dec_pc_i  in  DATA_W  instruction pc
rs1_rdata_i  in  DATA_W  rs1 operand
rs2_rdata_i  in  DATA_W  rs2 operand
req_o  out  NUM_GRP  one-hot request to channel g for head entry
ack_i  in  NUM_GRP  channel g accepts (ready)
disp_info_o  out  INFO_W  head info bus, zero when req_o==0
disp_imm_o / disp_pc_o / disp_rs1_o / disp_rs2_o  out  DATA_W each  head payload, zero when req_o==0
illegal_o  out  1  one-cycle pulse: head had group code >= NUM_GRP
illegal_pc_o  out  DATA_W  pc of illegal entry, valid with illegal_o, else 0
count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n=0 at posedge): count=0, rd/wr pointers=0; all outputs 0 except dec_ready_o=1. Storage contents not reset.
- Push: dec_valid_i & dec_ready_o & ~flush_i writes entry at wr_ptr, wr_ptr++ (mod DEPTH). dec_ready_o = (count_o != DEPTH), registered-count based; no push into full queue even if the head pops that cycle.
- Minimum latency: entry pushed in cycle N is visible at head (req_o) in cycle N+1; no combinational bypass.
- Head decode (combinational from storage): count!=0 and group g<NUM_GRP -> req_o[g]=1, payload = head entry. g>=NUM_GRP -> req_o=0, illegal_o=1, illegal_pc_o=head pc.
- Pop: (req_o & ack_i) != 0, or illegal_o=1 (illegal entry self-drops in one cycle). rd_ptr++.
- Handshake: req_o and payload stay stable until acked; ack_i bits not matching req_o are ignored; ack_i may be held high permanently (zero-stall issue, 1 instr/cycle).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: DEPTH power of two, pointers wrap naturally; count distinguishes full/empty.
- flush_i: at the next edge count=0 and rd_ptr=wr_ptr=0; same-cycle push dropped; same-cycle ack still completes for the channel (the unit has accepted) but the queue is cleared regardless. Flush has priority over push/pop; illegal_o in the flush cycle is still output combinationally.
- In-order only: a stalled head blocks younger entries for all channels.

Test Plan:
- Reset then push ALU (g=0) pc=0x100 with ack_i=all 1 -> req_o=6'b000001 one cycle later, disp_pc_o=0x100, count returns to 0; all payload outputs 0 afterwards.
- Push 4 entries (g=2 MULDIV) with ack_i=0 -> count_o=4, dec_ready_o=0, 5th push ignored; raise ack_i[2] -> entries drain one per cycle in push order, pc 0x0,0x4,0x8,0xC.
- Full queue, push and ack in same cycle -> push rejected (dec_ready_o=0); next cycle count=3 and dec_ready_o=1.
- Head g=7 (NUM_GRP=6) pc=0x200 -> illegal_o=1 for exactly one cycle, illegal_pc_o=0x200, req_o=0, next entry issues the following cycle.
- Queue holding 3 entries, flush_i=1 with dec_valid_i=1 -> next cycle count_o=0, req_o=0, pushed entry absent.
- Continuous push with ack_i=all 1 across 10 instructions -> pointers wrap past DEPTH, 1 issue/cycle, no lost or duplicated pc.
